id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-002 SHALL have ports: id_valid  in  1  decoded instruction present; id_alu_op  in  4  ALU opcode; id_rs_addr, id_rt_addr, id_rd_addr  in  4  register addresses, 4'hF = none.
REQ-003 SHALL have ports: id_rs_data, id_rt_data, id_imm  in  16  register-file operands / sign-extended immediate; id_use_imm, id_reg_write, id_mem_read, id_mem_write  in  1  decode controls.
REQ-004 SHALL have ports: flush  in  1  branch-taken squash; hold  in  1  structural freeze.
REQ-005 SHALL have ports: exm_reg_write, exm_mem_read  in  1; exm_rd_addr  in  4; exm_result  in  16  EX/MEM forwarding source.
REQ-006 SHALL have ports: wb_reg_write  in  1; wb_rd_addr  in  4; wb_data  in  16  MEM/WB forwarding source.
REQ-007 SHALL have ports: alu_op  out  4; alu_a, alu_b  out  16  ALU operands; ex_store_data  out  16; ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1; ex_rd_addr  out  4; stall_id  out  1  freeze PC/IF/ID; stall_count  out  16  bubbles inserted.

Function
REQ-008 SHALL register on rising clk: valid, alu_op, rs/rt/rd addrs, rs/rt data, imm, use_imm, reg_write, mem_read, mem_write.
REQ-009 SHALL update registers with priority flush > hold > load-use bubble > capture.
REQ-010 flush SHALL clear ex_valid and all control bits (reg_write, mem_read, mem_write) next edge, data fields don't-care.
REQ-011 hold (no flush) SHALL keep all registers and stall_count unchanged.
REQ-012 load-use hazard SHALL be: ex_valid & ex_mem_read & ex_rd_addr!=4'hF & id_valid & (ex_rd_addr==id_rs_addr | ex_rd_addr==id_rt_addr).
REQ-013 stall_id SHALL be combinational = hazard & ~flush; hold does not affect stall_id.
REQ-014 on hazard (no flush/hold) SHALL insert bubble: ex_valid=0, controls=0; stall_count += 1 saturating at 16'hFFFF.
REQ-015 otherwise SHALL capture id_* inputs; id_valid=0 captures a bubble.
REQ-016 rs operand SHALL forward: exm_result if exm_reg_write & ~exm_mem_read & exm_rd_addr==rs & rs!=4'hF; else wb_data if wb_reg_write & wb_rd_addr==rs & rs!=4'hF; else registered rs data.
REQ-017 rt operand SHALL forward by identical rule; EX/MEM SHALL beat MEM/WB on double match.
REQ-018 alu_a = forwarded rs; alu_b = use_imm ? imm : forwarded rt; ex_store_data = forwarded rt (combinational).
REQ-019 when ex_valid=0, alu_op SHALL be 4'b0000 (ADD), alu_a/alu_b/ex_store_data 16'h0000.
REQ-020 total latency id_* to alu_* SHALL be one cycle; stall costs exactly one bubble per load-use pair.
REQ-021 forwarding SHALL be recomputed every cycle, including while hold is asserted.

Reset
REQ-022 rst SHALL asynchronously clear all registers: ex_valid=0, controls=0, addrs=4'hF, data/imm=0, alu_op=0, stall_count=0.
REQ-023 rst mid-hazard SHALL drop stall_id to 0 immediately (ex_valid=0).
REQ-024 first capture SHALL occur on first rising clk after rst deasserts.

Verification
REQ-025 Capture: id ADD rs=1(16'h0005) rt=2(16'h0003), no forward match -> next cycle alu_op=0000, alu_a=0005, alu_b=0003, ex_valid=1.
REQ-026 Forward priority: ex rs=3; exm rd=3 result=16'hAAAA, wb rd=3 data=16'h5555 -> alu_a=AAAA; drop exm_reg_write -> alu_a=5555; exm_mem_read=1 -> 5555.
REQ-027 Load-use: ex LW rd=4; id rs=4 -> stall_id=1, next cycle ex_valid=0, stall_count=1; following cycle instruction captured.
REQ-028 Flush vs hazard: hazard + flush same cycle -> stall_id=0, next ex_valid=0, stall_count unchanged.
REQ-029 Hold: hold=1 three cycles with changing id_* -> ex_* unchanged; stall_count frozen at 16'hFFFF under hazard saturation check.
REQ-030 Async reset: assert rst mid-cycle with ex_valid=1 -> outputs zero, ex_rd_addr=4'hF, before next clk edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions, inserts load-use bubbles,
// and forwards EX/MEM and MEM/WB results onto the ALU operands.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_alu_op,
    input  logic [3:0]  id_rs_addr,
    input  logic [3:0]  id_rt_addr,
    input  logic [3:0]  id_rd_addr,
    input  logic [15:0] id_rs_data,
    input  logic [15:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic        id_use_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        hold,
    input  logic        exm_reg_write,
    input  logic        exm_mem_read,
    input  logic [3:0]  exm_rd_addr,
    input  logic [15:0] exm_result,
    input  logic        wb_reg_write,
    input  logic [3:0]  wb_rd_addr,
    input  logic [15:0] wb_data,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [3:0]  ex_rd_addr,
    output logic        stall_id,
    output logic [15:0] stall_count
);

    localparam logic [3:0] NO_REG = 4'hF;

    logic        valid_q;
    logic [3:0]  alu_op_q;
    logic [3:0]  rs_addr_q;
    logic [3:0]  rt_addr_q;
    logic [3:0]  rd_addr_q;
    logic [15:0] rs_data_q;
    logic [15:0] rt_data_q;
    logic [15:0] imm_q;
    logic        use_imm_q;
    logic        reg_write_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [15:0] stall_count_q;

    logic        hazard;
    logic [15:0] rs_fwd;
    logic [15:0] rt_fwd;

    function automatic logic [15:0] forward(
        input logic [3:0]  src,
        input logic [15:0] reg_val,
        input logic        exm_we,
        input logic        exm_ld,
        input logic [3:0]  exm_rd,
        input logic [15:0] exm_val,
        input logic        wb_we,
        input logic [3:0]  wb_rd,
        input logic [15:0] wb_val
    );
        if (src == NO_REG)
            return reg_val;
        // A load in EX/MEM has no result yet; the load-use bubble covers that case.
        if (exm_we && !exm_ld && (exm_rd == src))
            return exm_val;
        if (wb_we && (wb_rd == src))
            return wb_val;
        return reg_val;
    endfunction

    assign hazard = valid_q && mem_read_q && (rd_addr_q != NO_REG) && id_valid &&
                    ((rd_addr_q == id_rs_addr) || (rd_addr_q == id_rt_addr));

    assign stall_id = hazard && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            alu_op_q      <= 4'h0;
            rs_addr_q     <= NO_REG;
            rt_addr_q     <= NO_REG;
            rd_addr_q     <= NO_REG;
            rs_data_q     <= 16'h0000;
            rt_data_q     <= 16'h0000;
            imm_q         <= 16'h0000;
            use_imm_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            stall_count_q <= 16'h0000;
        end else if (flush) begin
            valid_q     <= 1'b0;
            rd_addr_q   <= NO_REG;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (hold) begin
            valid_q <= valid_q;
        end else if (hazard) begin
            // Bubble carries no destination so it cannot be mistaken for a producer.
            valid_q     <= 1'b0;
            rd_addr_q   <= NO_REG;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (stall_count_q != 16'hFFFF)
                stall_count_q <= stall_count_q + 16'h0001;
        end else begin
            valid_q     <= id_valid;
            alu_op_q    <= id_alu_op;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            rd_addr_q   <= id_rd_addr;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            use_imm_q   <= id_use_imm;
            reg_write_q <= id_valid && id_reg_write;
            mem_read_q  <= id_valid && id_mem_read;
            mem_write_q <= id_valid && id_mem_write;
        end
    end

    always_comb begin
        rs_fwd = forward(rs_addr_q, rs_data_q, exm_reg_write, exm_mem_read, exm_rd_addr,
                         exm_result, wb_reg_write, wb_rd_addr, wb_data);
        rt_fwd = forward(rt_addr_q, rt_data_q, exm_reg_write, exm_mem_read, exm_rd_addr,
                         exm_result, wb_reg_write, wb_rd_addr, wb_data);
    end

    always_comb begin
        alu_op        = 4'h0;
        alu_a         = 16'h0000;
        alu_b         = 16'h0000;
        ex_store_data = 16'h0000;
        if (valid_q) begin
            alu_op        = alu_op_q;
            alu_a         = rs_fwd;
            alu_b         = use_imm_q ? imm_q : rt_fwd;
            ex_store_data = rt_fwd;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign ex_rd_addr   = rd_addr_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: the driver queues hand-computed expected outputs,
// a monitor pops and compares them at the falling edge (or on demand mid-cycle).
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [3:0]  id_rs_addr;
    logic [3:0]  id_rt_addr;
    logic [3:0]  id_rd_addr;
    logic [15:0] id_rs_data;
    logic [15:0] id_rt_data;
    logic [15:0] id_imm;
    logic        id_use_imm;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        flush;
    logic        hold;
    logic        exm_reg_write;
    logic        exm_mem_read;
    logic [3:0]  exm_rd_addr;
    logic [15:0] exm_result;
    logic        wb_reg_write;
    logic [3:0]  wb_rd_addr;
    logic [15:0] wb_data;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] ex_store_data;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [3:0]  ex_rd_addr;
    logic        stall_id;
    logic [15:0] stall_count;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .hold(hold),
        .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
        .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd_addr(ex_rd_addr),
        .stall_id(stall_id), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, reg_write, mem_read, mem_write, stall_id, alu_op, rd, alu_a, alu_b, store, count}
    logic [76:0] exp_q[$];
    string       tag_q[$];
    int          errors;
    int          checks;
    logic        stim_done;
    event        sample_now;

    task automatic exp_out(input string tag, input logic v, input logic rw, input logic mr,
                           input logic mw, input logic st, input logic [3:0] op,
                           input logic [3:0] rd, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] sd, input logic [15:0] cnt);
        exp_q.push_back({v, rw, mr, mw, st, op, rd, a, b, sd, cnt});
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid     = 1'b0;
        id_alu_op    = 4'h0;
        id_rs_addr   = 4'hF;
        id_rt_addr   = 4'hF;
        id_rd_addr   = 4'hF;
        id_rs_data   = 16'h0000;
        id_rt_data   = 16'h0000;
        id_imm       = 16'h0000;
        id_use_imm   = 1'b0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        id_mem_write = 1'b0;
    endtask

    task automatic no_fwd();
        exm_reg_write = 1'b0;
        exm_mem_read  = 1'b0;
        exm_rd_addr   = 4'hF;
        exm_result    = 16'h0000;
        wb_reg_write  = 1'b0;
        wb_rd_addr    = 4'hF;
        wb_data       = 16'h0000;
    endtask

    task automatic set_id(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                          input logic [3:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                          input logic [15:0] imm, input logic ui, input logic rw,
                          input logic mr, input logic mw);
        id_valid     = 1'b1;
        id_alu_op    = op;
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        id_rd_addr   = rd;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_imm       = imm;
        id_use_imm   = ui;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
    endtask

    initial begin : monitor
        logic [76:0] act;
        logic [76:0] want;
        string       tag;
        int          cycles;
        errors = 0;
        checks = 0;
        cycles = 0;
        forever begin
            @(negedge clk or sample_now);
            cycles++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                tag  = tag_q.pop_front();
                act  = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_id, alu_op,
                        ex_rd_addr, alu_a, alu_b, ex_store_data, stall_count};
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL %s: got v/rw/mr/mw/st=%b op=%h rd=%h a=%h b=%h sd=%h cnt=%h ; want v/rw/mr/mw/st=%b op=%h rd=%h a=%h b=%h sd=%h cnt=%h",
                             tag, act[76:72], act[71:68], act[67:64], act[63:48], act[47:32],
                             act[31:16], act[15:0], want[76:72], want[71:68], want[67:64],
                             want[63:48], want[47:32], want[31:16], want[15:0]);
                end
            end else if (stim_done) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            if (cycles > 1000) begin
                errors++;
                $display("FAIL watchdog: got %0d cycles without completion, want at most 1000", cycles);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin : driver
        stim_done = 1'b0;
        rst   = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        idle_id();
        no_fwd();
        exp_out("reset", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        rst = 1'b0;

        set_id(4'h0, 4'h1, 4'h2, 4'h5, 16'h0005, 16'h0003, 16'h0000, 0, 1, 0, 0);
        exp_out("post_rst_empty", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        idle_id();
        exp_out("capture_add", 1,1,0,0,0, 4'h0, 4'h5, 16'h0005, 16'h0003, 16'h0003, 16'h0);
        tick();
        set_id(4'h3, 4'h6, 4'h7, 4'h8, 16'h1234, 16'h00FF, 16'hFFF0, 1, 1, 0, 0);
        exp_out("bubble_from_idle", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        set_id(4'h2, 4'h3, 4'h9, 4'hA, 16'h1111, 16'h2222, 16'h0000, 0, 1, 0, 0);
        exp_out("capture_imm", 1,1,0,0,0, 4'h3, 4'h8, 16'h1234, 16'hFFF0, 16'h00FF, 16'h0);
        tick();

        hold = 1'b1;
        exm_reg_write = 1'b1; exm_mem_read = 1'b0; exm_rd_addr = 4'h3; exm_result = 16'hAAAA;
        wb_reg_write = 1'b1; wb_rd_addr = 4'h3; wb_data = 16'h5555;
        set_id(4'h7, 4'hD, 4'hE, 4'h1, 16'hDEAD, 16'hBEEF, 16'h0001, 1, 1, 1, 1);
        exp_out("fwd_exm_priority", 1,1,0,0,0, 4'h2, 4'hA, 16'hAAAA, 16'h2222, 16'h2222, 16'h0);
        tick();
        exm_reg_write = 1'b0;
        set_id(4'h8, 4'hC, 4'hB, 4'h2, 16'h0F0F, 16'hF0F0, 16'h0002, 0, 0, 0, 1);
        exp_out("fwd_wb", 1,1,0,0,0, 4'h2, 4'hA, 16'h5555, 16'h2222, 16'h2222, 16'h0);
        tick();
        exm_reg_write = 1'b1; exm_mem_read = 1'b1;
        exp_out("fwd_exm_load_skip", 1,1,0,0,0, 4'h2, 4'hA, 16'h5555, 16'h2222, 16'h2222, 16'h0);
        tick();
        exm_mem_read = 1'b0; exm_rd_addr = 4'h9; exm_result = 16'h8888;
        wb_rd_addr = 4'h9; wb_data = 16'h7777;
        exp_out("fwd_rt_exm", 1,1,0,0,0, 4'h2, 4'hA, 16'h1111, 16'h8888, 16'h8888, 16'h0);
        tick();

        hold = 1'b0;
        no_fwd();
        set_id(4'h0, 4'h1, 4'hF, 4'h4, 16'h0100, 16'h0000, 16'h0004, 1, 1, 1, 0);
        exp_out("hold_kept", 1,1,0,0,0, 4'h2, 4'hA, 16'h1111, 16'h2222, 16'h2222, 16'h0);
        tick();
        set_id(4'h0, 4'h4, 4'h2, 4'h6, 16'h0009, 16'h0001, 16'h0000, 0, 1, 0, 0);
        exp_out("lw_hazard", 1,1,1,0,1, 4'h0, 4'h4, 16'h0100, 16'h0004, 16'h0000, 16'h0);
        tick();
        exp_out("load_use_bubble", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h1);
        tick();
        set_id(4'h0, 4'h1, 4'hF, 4'h4, 16'h0100, 16'h0000, 16'h0004, 1, 1, 1, 0);
        exp_out("after_bubble", 1,1,0,0,0, 4'h0, 4'h6, 16'h0009, 16'h0001, 16'h0001, 16'h1);
        tick();

        set_id(4'h0, 4'h4, 4'h2, 4'h6, 16'h0009, 16'h0001, 16'h0000, 0, 1, 0, 0);
        flush = 1'b1;
        exp_out("lw_flush_no_stall", 1,1,1,0,0, 4'h0, 4'h4, 16'h0100, 16'h0004, 16'h0000, 16'h1);
        tick();
        flush = 1'b0;
        set_id(4'h0, 4'h1, 4'hF, 4'h4, 16'h0100, 16'h0000, 16'h0004, 1, 1, 1, 0);
        exp_out("flush_bubble", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h1);
        tick();

        set_id(4'h0, 4'h4, 4'h2, 4'h6, 16'h0009, 16'h0001, 16'h0000, 0, 1, 0, 0);
        hold = 1'b1;
        exp_out("lw_hold_hazard", 1,1,1,0,1, 4'h0, 4'h4, 16'h0100, 16'h0004, 16'h0000, 16'h1);
        tick();
        set_id(4'h9, 4'h4, 4'h5, 4'h3, 16'h4444, 16'h5555, 16'h0000, 0, 1, 0, 1);
        exp_out("hold_frozen", 1,1,1,0,1, 4'h0, 4'h4, 16'h0100, 16'h0004, 16'h0000, 16'h1);
        tick();
        hold = 1'b0;
        exp_out("hold_released", 1,1,1,0,1, 4'h0, 4'h4, 16'h0100, 16'h0004, 16'h0000, 16'h1);
        tick();
        set_id(4'h0, 4'h2, 4'h3, 4'h7, 16'h00AA, 16'h0055, 16'h0010, 1, 1, 1, 0);
        exp_out("second_bubble", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h2);
        tick();

        set_id(4'h1, 4'h7, 4'h1, 4'h8, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0);
        exp_out("lw2_hazard", 1,1,1,0,1, 4'h0, 4'h7, 16'h00AA, 16'h0010, 16'h0055, 16'h2);
        #6;
        rst = 1'b1;
        #1;
        exp_out("async_reset", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0);
        -> sample_now;
        tick();

        rst = 1'b0;
        set_id(4'h6, 4'h1, 4'h2, 4'h3, 16'h0001, 16'h0002, 16'h0000, 0, 1, 0, 0);
        exp_out("post_rst2_empty", 0,0,0,0,0, 4'h0, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        idle_id();
        exp_out("first_capture", 1,1,0,0,0, 4'h6, 4'h3, 16'h0001, 16'h0002, 16'h0002, 16'h0);
        tick();
        stim_done = 1'b1;
    end

endmodule
